// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (fetch, load/store) and the byte RAM.
interface mem_arbiter_if;
  logic        in_fetch_ce;
  logic [31:0] in_fetch_pc;
  logic        in_flush;
  logic        out_fetch_ce;
  logic [31:0] out_fetch_instr;
  logic        in_lsb_ce;
  logic        in_lsb_wr;
  logic [1:0]  in_lsb_size;
  logic [31:0] in_lsb_addr;
  logic [31:0] in_lsb_data;
  logic        out_lsb_ce;
  logic [31:0] out_lsb_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  in_fetch_ce, in_fetch_pc, in_flush,
    input  in_lsb_ce, in_lsb_wr, in_lsb_size, in_lsb_addr, in_lsb_data,
    input  mem_din,
    output out_fetch_ce, out_fetch_instr, out_lsb_ce, out_lsb_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output in_fetch_ce, in_fetch_pc, in_flush,
    output in_lsb_ce, in_lsb_wr, in_lsb_size, in_lsb_addr, in_lsb_data,
    output mem_din,
    input  out_fetch_ce, out_fetch_instr, out_lsb_ce, out_lsb_data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto a byte-wide RAM; LSB has priority,
// transactions run back to back, fetches can be flushed, rdy freezes everything.
module mem_arbiter (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, nbytes;
  logic        own_fetch;
  logic [31:0] base, wdata, rbuf, rb_n;
  logic        fetch_pend, lsb_pend;
  logic [31:0] f_pc, l_addr, l_data;
  logic        l_wr;
  logic [1:0]  l_size;
  logic        act_q;
  logic [7:0]  din_hold, byte_in;
  logic        wr_q;
  logic [31:0] mem_a_q, fetch_instr_q, lsb_data_q;
  logic [7:0]  mem_dout_q;
  logic        fetch_ce_q, lsb_ce_q;
  logic        abort, rd_done, wr_done, free, grant_lsb, grant_fetch;
  logic        issue, capture, wr_drive;
  logic [1:0]  idx;
  logic        fetch_acc, lsb_acc;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign fetch_acc = bus.in_fetch_ce & ~fetch_pend & ~bus.in_flush;
  assign lsb_acc   = bus.in_lsb_ce & ~lsb_pend;

  // State register
  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_n;
  end

  // Next-state: completion edges double as grant edges so there is no bubble
  always_comb begin
    abort       = (state == READ) && own_fetch && bus.in_flush;
    rd_done     = (state == READ) && (cnt == nbytes + 3'd1) && !abort;
    wr_done     = (state == WRITE) && (cnt == nbytes);
    free        = (state == IDLE) || rd_done || wr_done;
    grant_lsb   = free && lsb_pend;
    grant_fetch = free && !lsb_pend && fetch_pend && !bus.in_flush;
    state_n     = state;
    if (abort)                     state_n = IDLE;
    else if (grant_lsb)            state_n = l_wr ? WRITE : READ;
    else if (grant_fetch)          state_n = READ;
    else if (rd_done || wr_done)   state_n = IDLE;
  end

  // Output decode: byte issue/capture strobes and the assembled read word
  always_comb begin
    issue    = (state == READ) && (cnt < nbytes);
    capture  = (state == READ) && (cnt >= 3'd2);
    wr_drive = (state == WRITE) && (cnt < nbytes);
    idx      = cnt[1:0] - 2'd2;
    // After a stall the RAM has moved on to the held address; use the byte latched at stall entry
    byte_in  = act_q ? bus.mem_din : din_hold;
    rb_n     = rbuf;
    if (capture) rb_n[{idx, 3'b000} +: 8] = byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; nbytes <= '0; own_fetch <= 1'b0; base <= '0; wdata <= '0; rbuf <= '0;
      fetch_pend <= 1'b0; lsb_pend <= 1'b0;
      f_pc <= '0; l_addr <= '0; l_data <= '0; l_wr <= 1'b0; l_size <= '0;
      act_q <= 1'b0; din_hold <= '0; wr_q <= 1'b0;
      mem_a_q <= '0; mem_dout_q <= '0; fetch_instr_q <= '0; lsb_data_q <= '0;
      fetch_ce_q <= 1'b0; lsb_ce_q <= 1'b0;
    end else begin
      act_q <= rdy;
      if (act_q) din_hold <= bus.mem_din;
      if (rdy) begin
        fetch_pend <= bus.in_flush ? 1'b0 : ((fetch_pend & ~grant_fetch) | fetch_acc);
        lsb_pend   <= (lsb_pend & ~grant_lsb) | lsb_acc;
        if (fetch_acc) f_pc <= bus.in_fetch_pc;
        if (lsb_acc) begin
          l_wr   <= bus.in_lsb_wr;
          l_size <= bus.in_lsb_size;
          l_addr <= bus.in_lsb_addr;
          l_data <= bus.in_lsb_data;
        end

        fetch_ce_q <= rd_done & own_fetch;
        lsb_ce_q   <= (rd_done & ~own_fetch) | wr_done;
        if (rd_done &  own_fetch) fetch_instr_q <= rb_n;
        if (rd_done & ~own_fetch) lsb_data_q    <= rb_n;

        wr_q       <= wr_drive;
        mem_dout_q <= wr_drive ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
        if (issue || wr_drive) mem_a_q <= base + {29'd0, cnt};

        if (grant_lsb || grant_fetch) begin
          cnt       <= '0;
          rbuf      <= '0;
          own_fetch <= grant_fetch;
          base      <= grant_fetch ? f_pc : l_addr;
          nbytes    <= grant_fetch ? 3'd4 : size_bytes(l_size);
          wdata     <= l_data;
        end else if (abort || rd_done || wr_done || state == IDLE) begin
          cnt  <= '0;
          rbuf <= rb_n;
        end else begin
          cnt  <= cnt + 3'd1;
          rbuf <= rb_n;
        end
      end
    end
  end

  assign bus.mem_wr          = wr_q & rdy;
  assign bus.mem_a           = mem_a_q;
  assign bus.mem_dout        = mem_dout_q;
  assign bus.out_fetch_ce    = fetch_ce_q;
  assign bus.out_fetch_instr = fetch_instr_q;
  assign bus.out_lsb_ce      = lsb_ce_q;
  assign bus.out_lsb_data    = lsb_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model plus hand-computed expectations.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst, rdy;
  int   pass_cnt = 0;
  int   total = 0;
  logic seen, ok;
  logic [7:0] ram [0:1023];

  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  // Byte RAM: address in cycle k, data in cycle k+1; writes land on the edge closing the strobe cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05; ram[10'h102] <= 8'h00; ram[10'h103] <= 8'h00;
      ram[10'h020] <= 8'h34; ram[10'h021] <= 8'h12;
      ram[10'h040] <= 8'h11; ram[10'h041] <= 8'h22; ram[10'h042] <= 8'h33;
      bus.mem_din <= 8'h00;
    end else begin
      bus.mem_din <= ram[bus.mem_a[9:0]];
      if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic lsb_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.in_lsb_ce = 1'b1; bus.in_lsb_wr = wr; bus.in_lsb_size = sz;
    bus.in_lsb_addr = a; bus.in_lsb_data = d;
  endtask

  initial begin
    bus.in_fetch_ce = 0; bus.in_fetch_pc = 0; bus.in_flush = 0;
    bus.in_lsb_ce = 0; bus.in_lsb_wr = 0; bus.in_lsb_size = 0; bus.in_lsb_addr = 0; bus.in_lsb_data = 0;
    rst = 1; rdy = 1;
    tick(2);
    chk("rst_fetch_ce", 32'(bus.out_fetch_ce), 0);
    chk("rst_lsb_ce", 32'(bus.out_lsb_ce), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_instr", bus.out_fetch_instr, 0);
    chk("rst_lsb_data", bus.out_lsb_data, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 0);
    rst = 0; tick;

    // Plain fetch: four consecutive addresses, pulse 6 cycles after grant
    bus.in_fetch_ce = 1; bus.in_fetch_pc = 32'h100; tick; bus.in_fetch_ce = 0;
    tick;
    for (int i = 0; i < 4; i++) begin tick; chk("fetch_addr", bus.mem_a, 32'h100 + 32'(i)); end
    chk("fetch_no_wr", 32'(bus.mem_wr), 0);
    tick; chk("fetch_early", 32'(bus.out_fetch_ce), 0);
    tick; chk("fetch_ce", 32'(bus.out_fetch_ce), 1); chk("fetch_instr", bus.out_fetch_instr, 32'h00000513);
    tick; chk("fetch_pulse", 32'(bus.out_fetch_ce), 0);

    // Simultaneous fetch + load: load first, fetch granted on the load's completion edge
    bus.in_fetch_ce = 1; bus.in_fetch_pc = 32'h100; lsb_req(0, 2'd1, 32'h20, 0);
    tick; bus.in_fetch_ce = 0; bus.in_lsb_ce = 0;
    tick; tick; chk("lsb_first", bus.mem_a, 32'h20);
    tick(3); chk("load_ce", 32'(bus.out_lsb_ce), 1); chk("load_data", bus.out_lsb_data, 32'h00001234);
    chk("load_no_fetch", 32'(bus.out_fetch_ce), 0);
    tick; chk("fetch_next", bus.mem_a, 32'h100);
    tick(5); chk("fetch2_ce", 32'(bus.out_fetch_ce), 1);

    // Two-byte store
    lsb_req(1, 2'd1, 32'h40, 32'hDEADBEEF); tick; bus.in_lsb_ce = 0;
    tick; tick;
    chk("st0_wr", 32'(bus.mem_wr), 1); chk("st0_a", bus.mem_a, 32'h40); chk("st0_d", 32'(bus.mem_dout), 32'hEF);
    tick;
    chk("st1_wr", 32'(bus.mem_wr), 1); chk("st1_a", bus.mem_a, 32'h41); chk("st1_d", 32'(bus.mem_dout), 32'hBE);
    tick;
    chk("st_ce", 32'(bus.out_lsb_ce), 1); chk("st_wr_off", 32'(bus.mem_wr), 0); chk("st_dout_off", 32'(bus.mem_dout), 0);
    chk("st_hold_data", bus.out_lsb_data, 32'h00001234);
    chk("ram40", 32'(ram[10'h040]), 32'hEF); chk("ram41", 32'(ram[10'h041]), 32'hBE);
    chk("ram42", 32'(ram[10'h042]), 32'h33);

    // Flush three cycles into a fetch
    bus.in_fetch_ce = 1; bus.in_fetch_pc = 32'h100; tick; bus.in_fetch_ce = 0;
    tick; tick(2); bus.in_flush = 1; tick; bus.in_flush = 0;
    seen = 0; repeat (8) begin tick; seen |= bus.out_fetch_ce; end
    chk("flush_abort", 32'(seen), 0);
    bus.in_fetch_ce = 1; bus.in_flush = 1; bus.in_fetch_pc = 32'h104; tick; bus.in_fetch_ce = 0; bus.in_flush = 0;
    seen = 0; repeat (10) begin tick; seen |= bus.out_fetch_ce; end
    chk("flush_drop", 32'(seen), 0);
    bus.in_fetch_ce = 1; bus.in_fetch_pc = 32'h104; tick; bus.in_fetch_ce = 0;
    tick; tick(6);
    chk("refetch_ce", 32'(bus.out_fetch_ce), 1); chk("refetch_instr", bus.out_fetch_instr, 32'h5D5C5F5E);

    // rdy low for five edges in the middle of a 4-byte load
    lsb_req(0, 2'd2, 32'h40, 0); tick; bus.in_lsb_ce = 0;
    tick; tick; tick;
    rdy = 0; ok = 1;
    repeat (5) begin tick; ok &= (bus.mem_a == 32'h41) && !bus.mem_wr && !bus.out_lsb_ce; end
    chk("stall_hold", 32'(ok), 1);
    rdy = 1;
    tick(3); chk("stall_late", 32'(bus.out_lsb_ce), 0);
    tick; chk("stall_ce", 32'(bus.out_lsb_ce), 1); chk("stall_data", bus.out_lsb_data, 32'h1933BEEF);

    // Size 3 behaves as 4 bytes; address wraps past 0xFFFFFFFF
    lsb_req(0, 2'd3, 32'hFFFFFFFE, 0); tick; bus.in_lsb_ce = 0;
    tick; tick; chk("wrap_a0", bus.mem_a, 32'hFFFFFFFE);
    tick(2); chk("wrap_a2", bus.mem_a, 32'h0);
    tick(3); chk("sz3_ce", 32'(bus.out_lsb_ce), 1); chk("sz3_data", bus.out_lsb_data, 32'h5B5AA5A4);

    // Single-byte load is zero-extended
    lsb_req(0, 2'd0, 32'h101, 0); tick; bus.in_lsb_ce = 0;
    tick; tick(3); chk("b_ce", 32'(bus.out_lsb_ce), 1); chk("b_data", bus.out_lsb_data, 32'h00000005);

    // Reset in the middle of a store
    lsb_req(1, 2'd2, 32'h80, 32'h01020304); tick; bus.in_lsb_ce = 0;
    tick; tick; chk("rs_pre_wr", 32'(bus.mem_wr), 1);
    rst = 1; tick;
    chk("rs_wr", 32'(bus.mem_wr), 0); chk("rs_a", bus.mem_a, 0); chk("rs_dout", 32'(bus.mem_dout), 0);
    chk("rs_lsb_data", bus.out_lsb_data, 0); chk("rs_instr", bus.out_fetch_instr, 0);
    rst = 0;
    seen = 0; repeat (8) begin tick; seen |= bus.out_lsb_ce | bus.mem_wr; end
    chk("rs_no_ce", 32'(seen), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
